seg_mux_reader: RTL and testbench
=================================

Name: seg_mux_reader

Overview:
Reads back a multiplexed 4-digit, 7-segment display bus (active-low segments and anodes), the receiving end of the scrolling-text display driver. Demultiplexes the bus into four per-digit segment registers and decodes each digit to a hex code. Flags complete frames and frame changes. Used for loopback self-test on the board and as a bus monitor in simulation benches.

Parameters:
SETTLE_CYCLES, 16, consecutive cycles anode+segments must be unchanged before a digit is sampled (min 2)
TIMEOUT_CYCLES, 1048576, cycles without any capture before the stale flag asserts
CNT_W, 21, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
seg_n  in  8  segment lines, active-low; bit0=a..bit6=g, bit7=dp
an_n  in  4  anode lines, active-low; bit i selects digit i
digit_raw  out  32  captured segment patterns, active-high; digit i in bits [8i+7:8i]
digit_code  out  16  decoded hex value; digit i in bits [4i+3:4i]
code_ok  out  4  bit i=1 when digit i matched a hex glyph (dp ignored)
frame_valid  out  1  1-cycle pulse: all four digits captured since last pulse
frame_changed  out  1  1-cycle pulse, coincident with frame_valid, when digit_raw differs from the previous frame
stale  out  1  no capture for TIMEOUT_CYCLES

Behaviour:
- Reset: all outputs 0; seen mask 0; previous-frame register 0; FSM in IDLE; counters 0.
- Input stage: seg_n/an_n registered once, inverted to active-high (seg_q, an_q). All decisions use registered values. Total 1 cycle of input latency.
- FSM, evaluated each cycle on seg_q/an_q vs. their values one cycle earlier:
  - IDLE: an_q not one-hot (0 or >1 bits set). Stay. On one-hot -> SETTLE, settle_cnt=1.
  - SETTLE: if an_q or seg_q changed -> restart (settle_cnt=1 if still one-hot, else IDLE). Else settle_cnt++. When settle_cnt reaches SETTLE_CYCLES -> CAPTURE.
  - CAPTURE (1 cycle): write seg_q into digit_raw slot i (i = index of an_q); write decode into digit_code[i]/code_ok[i]; set seen[i]; clear timeout counter -> HOLD.
  - HOLD: no re-capture while an_q/seg_q unchanged. Any change -> as SETTLE restart rule.
- Outputs update the cycle after CAPTURE. Latency from a stable bus to the digit update is 1 + SETTLE_CYCLES + 1 cycles.
- Decode: seg_q[6:0] compared against a 16-entry glyph table. 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. On a match, code=index and ok=1. On no match (including blank 00), code=0 and ok=0.
- Frame: when the seen mask becomes 1111 through a capture, frame_valid pulses in the same cycle as the digit outputs update. frame_changed=1 if the new digit_raw != prev_frame. prev_frame<=digit_raw. seen<=0. A digit re-captured before the frame completes overwrites its slot; the mask is unchanged.
- Timeout: the counter increments every cycle not in CAPTURE and saturates at TIMEOUT_CYCLES. stale=1 while saturated; seen is cleared on entry to saturation. The next capture clears stale in the same cycle the digit updates. digit_raw is kept.
- Simultaneous anode and segment change: treated as one change, single restart.
- Reset mid-SETTLE or mid-frame: everything returns to reset values the next cycle. No pulse is emitted.

Decomposition:
- Package seg_pkg: glyph table constants (16x7), segment bit-index constants, an is_onehot4 function, and an FSM state typedef (IDLE, SETTLE, CAPTURE, HOLD).
- One sub-module, seg_glyph_decode: combinational 7-bit pattern -> {ok, code[3:0]}. Shared with future display-side blocks.

Test Plan:
- Drive an_n=1110 with seg_n=~3F held 20 cycles -> digit_code[3:0]=0, code_ok[0]=1 exactly 1+16+1 cycles after the inputs are applied; no frame_valid.
- Cycle digits 0..3 showing 1,2,3,4 (glyphs 06,5B,4F,66), 32 cycles each -> one frame_valid pulse, frame_changed=1, digit_code=16'h4321. Repeating the same frame -> frame_valid=1, frame_changed=0.
- Toggle seg_n every 10 cycles with an_n fixed -> no capture ever (SETTLE=16). Then hold 16 cycles -> capture occurs.
- an_n=1100 (two active) and an_n=1111 held 100 cycles -> FSM stays IDLE, outputs unchanged.
- Pattern seg=~49 on digit 2 -> code_ok[2]=0, digit_code[11:8]=0, digit_raw[23:16]=49. With dp set (~BF) on digit 1 -> code 0, ok=1, raw=BF.
- With TIMEOUT_CYCLES=64, stop driving changes after a capture -> stale=1 after 64 cycles. A new capture clears stale. rst asserted mid-frame -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, helpers and FSM state type for the 7-segment bus reader
//
// Purpose: hex glyph table (segment a = bit 0 .. g = bit 6, active-high),
//          segment bit positions, a one-hot test for the 4-bit anode bus and
//          the capture FSM state type.
// Ports:   none (package).
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Entry k is the active-high a..g pattern that displays hex digit k.
  localparam logic [15:0][6:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_HOLD
  } state_e;

  function automatic logic is_onehot4(input logic [3:0] v);
    case (v)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// rtl/seg_glyph_decode.sv - combinational 7-segment pattern to hex digit decoder
//
// Purpose: looks up an active-high a..g pattern in the hex glyph table.
// Ports:   pattern_i  7  segment pattern, bit 0 = a .. bit 6 = g
//          ok_o       1  pattern is one of the 16 hex glyphs
//          code_o     4  matching hex value, 0 when ok_o is 0
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic       ok_o,
  output logic [3:0] code_o
);

  always_comb begin
    ok_o   = 1'b0;
    code_o = 4'h0;
    // Glyphs are all distinct, so at most one entry can match.
    for (int k = 0; k < 16; k++) begin
      if (pattern_i == GLYPHS[k]) begin
        ok_o   = 1'b1;
        code_o = 4'(k);
      end
    end
  end

endmodule

// File: rtl/seg_mux_reader.sv
// rtl/seg_mux_reader.sv - reads back a multiplexed 4-digit 7-segment display bus
//
// Purpose: registers and inverts the active-low bus, waits for the anode and
//          segment lines to be stable for SETTLE_CYCLES, then captures the
//          selected digit, decodes it to hex, tracks complete frames and
//          flags a stale bus after TIMEOUT_CYCLES without a capture.
// Ports:   clk            system clock
//          rst            synchronous reset, active-high
//          seg_n[7:0]     segment lines, active-low, bit 0 = a .. bit 6 = g, bit 7 = dp
//          an_n[3:0]      anode lines, active-low, bit i selects digit i
//          digit_raw[31:0]   captured patterns, active-high, digit i in [8i+7:8i]
//          digit_code[15:0]  decoded hex, digit i in [4i+3:4i]
//          code_ok[3:0]      digit i matched a hex glyph
//          frame_valid       1-cycle pulse when all four digits have been captured
//          frame_changed     with frame_valid, frame differs from the previous one
//          stale             no capture for TIMEOUT_CYCLES
module seg_mux_reader
  import seg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = 21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [31:0] digit_raw,
  output logic [15:0] digit_code,
  output logic [3:0]  code_ok,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic        stale
);

  localparam int               SET_W       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(TIMEOUT_CYCLES);

  // Input stage: current registered bus and its value one cycle earlier.
  logic [7:0] seg_q, seg_prev_q;
  logic [3:0] an_q,  an_prev_q;

  state_e           state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]       seen_q, seen_d;
  logic [31:0]      prev_q, prev_d;
  logic [31:0]      raw_q, raw_d;
  logic [15:0]      code_q, code_d;
  logic [3:0]       ok_q, ok_d;
  logic             fv_q, fv_d;
  logic             fc_q, fc_d;

  logic       changed;
  logic       capture;
  logic       dec_ok;
  logic [3:0] dec_code;
  logic [3:0] seen_merge;

  // Anode and segment changes in the same cycle count as a single change.
  assign changed = (seg_q != seg_prev_q) || (an_q != an_prev_q);

  // The capture cycle uses the previous-cycle bus: it is the value that was
  // proven stable, and stays correct even if the bus moves during CAPTURE.
  seg_glyph_decode u_decode (
    .pattern_i (seg_prev_q[SEG_G:SEG_A]),
    .ok_o      (dec_ok),
    .code_o    (dec_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q      <= 8'h00;
      an_q       <= 4'h0;
      seg_prev_q <= 8'h00;
      an_prev_q  <= 4'h0;
      state_q    <= ST_IDLE;
      settle_q   <= '0;
      to_cnt_q   <= '0;
      seen_q     <= 4'h0;
      prev_q     <= 32'h0;
      raw_q      <= 32'h0;
      code_q     <= 16'h0;
      ok_q       <= 4'h0;
      fv_q       <= 1'b0;
      fc_q       <= 1'b0;
    end else begin
      seg_q      <= ~seg_n;
      an_q       <= ~an_n;
      seg_prev_q <= seg_q;
      an_prev_q  <= an_q;
      state_q    <= state_d;
      settle_q   <= settle_d;
      to_cnt_q   <= to_cnt_d;
      seen_q     <= seen_d;
      prev_q     <= prev_d;
      raw_q      <= raw_d;
      code_q     <= code_d;
      ok_q       <= ok_d;
      fv_q       <= fv_d;
      fc_q       <= fc_d;
    end
  end

  // Capture FSM.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    capture  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_onehot4(an_q)) begin
          state_d  = ST_SETTLE;
          settle_d = SET_W'(1);
        end
      end
      ST_SETTLE: begin
        if (changed) begin
          state_d  = is_onehot4(an_q) ? ST_SETTLE : ST_IDLE;
          settle_d = is_onehot4(an_q) ? SET_W'(1) : '0;
        end else begin
          settle_d = settle_q + SET_W'(1);
          if (settle_q == SETTLE_LAST) begin
            state_d = ST_CAPTURE;
          end
        end
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        if (changed) begin
          state_d  = is_onehot4(an_q) ? ST_SETTLE : ST_IDLE;
          settle_d = is_onehot4(an_q) ? SET_W'(1) : '0;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (changed) begin
          state_d  = is_onehot4(an_q) ? ST_SETTLE : ST_IDLE;
          settle_d = is_onehot4(an_q) ? SET_W'(1) : '0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        settle_d = '0;
      end
    endcase
  end

  // Digit registers, frame tracking and timeout.
  always_comb begin
    to_cnt_d   = to_cnt_q;
    seen_d     = seen_q;
    prev_d     = prev_q;
    raw_d      = raw_q;
    code_d     = code_q;
    ok_d       = ok_q;
    fv_d       = 1'b0;
    fc_d       = 1'b0;
    seen_merge = seen_q | an_prev_q;
    if (capture) begin
      to_cnt_d = '0;
      for (int k = 0; k < 4; k++) begin
        if (an_prev_q[k]) begin
          raw_d[8*k +: 8]  = {seg_prev_q[SEG_DP], seg_prev_q[SEG_G:SEG_A]};
          code_d[4*k +: 4] = dec_code;
          ok_d[k]          = dec_ok;
        end
      end
      if (seen_merge == 4'hF) begin
        fv_d   = 1'b1;
        fc_d   = (raw_d != prev_q);
        prev_d = raw_d;
        seen_d = 4'h0;
      end else begin
        seen_d = seen_merge;
      end
    end else if (to_cnt_q != TIMEOUT_MAX) begin
      to_cnt_d = to_cnt_q + CNT_W'(1);
      // A frame must not span a stale gap, so partial progress is dropped.
      if (to_cnt_d == TIMEOUT_MAX) begin
        seen_d = 4'h0;
      end
    end
  end

  assign digit_raw     = raw_q;
  assign digit_code    = code_q;
  assign code_ok       = ok_q;
  assign frame_valid   = fv_q;
  assign frame_changed = fc_q;
  assign stale         = (to_cnt_q == TIMEOUT_MAX);

endmodule

// File: tb/tb_seg_mux_reader.sv
// tb/tb_seg_mux_reader.sv - scoreboard bench for seg_mux_reader
module tb_seg_mux_reader;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 64;
  localparam int LAT     = SETTLE + 2;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  seg_n = 8'hFF;
  logic [3:0]  an_n = 4'hF;
  logic [31:0] digit_raw;
  logic [15:0] digit_code;
  logic [3:0]  code_ok;
  logic        frame_valid;
  logic        frame_changed;
  logic        stale;

  seg_mux_reader #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (7)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .seg_n         (seg_n),
    .an_n          (an_n),
    .digit_raw     (digit_raw),
    .digit_code    (digit_code),
    .code_ok       (code_ok),
    .frame_valid   (frame_valid),
    .frame_changed (frame_changed),
    .stale         (stale)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rst_d = 1'b1;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  typedef struct {
    int         t;
    logic [3:0] an;
    logic [7:0] raw;
  } cap_t;

  typedef struct {
    int          t;
    logic [31:0] raw;
    logic        chg;
  } frame_t;

  cap_t   cap_q[$];
  frame_t frame_q[$];

  // Stimulus-side model: future digit contents and frame progress.
  logic [31:0] m_raw = 32'h0;
  logic [31:0] m_prev = 32'h0;
  logic [3:0]  m_seen = 4'h0;
  int          m_last = 0;
  logic [3:0]  last_an = 4'h0;
  logic [7:0]  last_seg = 8'h00;

  function automatic logic [4:0] ref_decode(input logic [7:0] raw);
    for (int i = 0; i < 16; i++) begin
      if (raw[6:0] == GLYPH[i]) return {1'b1, 4'(i)};
    end
    return 5'h00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one bus value; it will be held for n sampled cycles by the caller.
  // A one-hot value held at least SETTLE cycles lands on the outputs LAT
  // cycles after it is applied.
  task automatic apply(input logic [3:0] an, input logic [7:0] seg, input int n);
    cap_t   c;
    frame_t f;
    an_n     = ~an;
    seg_n    = ~seg;
    last_an  = an;
    last_seg = seg;
    if ($countones(an) == 1 && n >= SETTLE) begin
      c.t   = cyc + LAT;
      c.an  = an;
      c.raw = seg;
      if (c.t - m_last > TIMEOUT) m_seen = 4'h0;
      for (int k = 0; k < 4; k++) begin
        if (an[k]) begin
          m_raw[8*k +: 8] = seg;
          m_seen[k]       = 1'b1;
        end
      end
      cap_q.push_back(c);
      m_last = c.t;
      if (m_seen == 4'hF) begin
        f.t   = c.t;
        f.raw = m_raw;
        f.chg = (m_raw != m_prev);
        frame_q.push_back(f);
        m_prev = m_raw;
        m_seen = 4'h0;
      end
    end
  endtask

  task automatic run(input logic [3:0] an, input logic [7:0] seg, input int n);
    apply(an, seg, n);
    wait_cycles(n);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    an_n  = 4'hF;
    seg_n = 8'hFF;
    wait_cycles(1);
    cap_q.delete();
    frame_q.delete();
    m_raw    = 32'h0;
    m_prev   = 32'h0;
    m_seen   = 4'h0;
    last_an  = 4'h0;
    last_seg = 8'h00;
    wait_cycles(2);
    rst    = 1'b0;
    m_last = cyc;
  endtask

  // Monitor: tracks visible digit state from capture events and pops the
  // frame scoreboard whenever the DUT pulses frame_valid.
  logic [31:0] r_raw = 32'h0;
  int          r_last = 0;

  always @(negedge clk) begin
    cap_t        c;
    frame_t      f;
    logic [4:0]  d;
    logic [15:0] e_code;
    logic [3:0]  e_ok;
    if (rst_d) begin
      check("reset_raw", digit_raw, 32'h0);
      check("reset_misc", 32'({digit_code, code_ok, frame_valid, frame_changed, stale}), 32'h0);
      r_raw  = 32'h0;
      r_last = cyc;
    end else begin
      while (cap_q.size() > 0 && cap_q[0].t <= cyc) begin
        c = cap_q.pop_front();
        for (int k = 0; k < 4; k++) begin
          if (c.an[k]) r_raw[8*k +: 8] = c.raw;
        end
        r_last = c.t;
      end
      for (int k = 0; k < 4; k++) begin
        d = ref_decode(r_raw[8*k +: 8]);
        e_code[4*k +: 4] = d[3:0];
        e_ok[k]          = d[4];
      end
      check("digit_raw", digit_raw, r_raw);
      check("digit_code", 32'(digit_code), 32'(e_code));
      check("code_ok", 32'(code_ok), 32'(e_ok));
      check("stale", 32'(stale), 32'(cyc - r_last >= TIMEOUT));
      if (frame_valid) begin
        if (frame_q.size() == 0 || frame_q[0].t != cyc) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: got frame_valid=1 expected 0 at cycle %0d", cyc);
        end else begin
          f = frame_q.pop_front();
          check("frame_raw", digit_raw, f.raw);
          check("frame_changed", 32'(frame_changed), 32'(f.chg));
        end
      end else begin
        check("frame_changed_idle", 32'(frame_changed), 32'h0);
        if (frame_q.size() > 0 && frame_q[0].t <= cyc) begin
          checks++;
          errors++;
          $display("FAIL frame_missing: got frame_valid=0 expected 1 at cycle %0d", cyc);
          void'(frame_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish by time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0] an;
    logic [7:0] seg;
    int         n;

    do_reset();

    // Single digit with exact latency.
    apply(4'b0001, 8'h3F, 20);
    wait_cycles(LAT - 1);
    check("latency_before", 32'(code_ok[0]), 32'h0);
    wait_cycles(1);
    check("latency_ok", 32'(code_ok[0]), 32'h1);
    check("latency_code", 32'(digit_code[3:0]), 32'h0);
    wait_cycles(20 - LAT);

    // Full frame twice: first changed, second identical.
    for (int rep = 0; rep < 2; rep++) begin
      run(4'b0001, 8'h06, 32);
      run(4'b0010, 8'h5B, 32);
      run(4'b0100, 8'h4F, 32);
      run(4'b1000, 8'h66, 32);
      check("frame_code", 32'(digit_code), 32'h4321);
      check("frame_ok", 32'(code_ok), 32'hF);
    end

    // Bus never settles, then holds exactly SETTLE cycles.
    for (int k = 0; k < 6; k++) run(4'b0001, (k % 2 == 1) ? 8'h06 : 8'h5B, 10);
    check("toggle_no_capture", 32'(digit_code[3:0]), 32'h1);
    run(4'b0001, 8'h4F, SETTLE);
    wait_cycles(2);
    check("hold_capture", 32'(digit_code[3:0]), 32'h3);

    // Invalid anode patterns, long enough to go stale.
    run(4'b0011, 8'h06, 100);
    run(4'b0000, 8'h06, 100);
    check("stale_set", 32'(stale), 32'h1);
    check("stale_keeps_raw", 32'(digit_raw[7:0]), 32'h4F);

    // Non-glyph and decimal point.
    run(4'b0100, 8'h49, 30);
    check("bad_ok", 32'(code_ok[2]), 32'h0);
    check("bad_code", 32'(digit_code[11:8]), 32'h0);
    check("bad_raw", 32'(digit_raw[23:16]), 32'h49);
    check("stale_clear", 32'(stale), 32'h0);
    run(4'b0010, 8'hBF, 30);
    check("dp_ok", 32'(code_ok[1]), 32'h1);
    check("dp_code", 32'(digit_code[7:4]), 32'h0);
    check("dp_raw", 32'(digit_raw[15:8]), 32'hBF);

    // Reset mid-frame and mid-settle.
    run(4'b0001, 8'h06, 20);
    run(4'b1000, 8'h5B, 8);
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      do begin
        case ($urandom_range(0, 9))
          0:       an = 4'b0000;
          1:       an = ($urandom_range(0, 1) == 1) ? 4'b0011 : 4'b1110;
          default: an = 4'(1 << $urandom_range(0, 3));
        endcase
        if ($urandom_range(0, 3) == 0) seg = 8'($urandom);
        else seg = {1'($urandom), GLYPH[$urandom_range(0, 15)]};
      end while (an == last_an && seg == last_seg);
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(2, SETTLE - 1) : $urandom_range(SETTLE, 34);
      if ($countones(an) != 1 && $urandom_range(0, 2) == 0) n = $urandom_range(40, 90);
      run(an, seg, n);
      if (i == 180) do_reset();
    end

    wait_cycles(LAT + 10);
    check("frames_drained", 32'(frame_q.size()), 32'h0);
    check("captures_drained", 32'(cap_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
